// File: rtl/dot_mac_accumulator.sv
// Dot-product MAC: multiplies VECTOR_WIDTH operand pairs, accumulates them, and hands the sum out over valid/ready.
// Define DOT_SIGNED_EN to treat operands and the accumulation as two's complement (default: unsigned).
module dot_mac_accumulator #(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ACC_WIDTH    = 18,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VECTOR_WIDTH - 1);

  state_t                    state_q;
  logic [CNT_WIDTH-1:0]      cnt_q;
  logic [2*DATA_WIDTH-1:0]   prod_q;
  logic                      prodVld_q;
  logic [ACC_WIDTH-1:0]      acc_q;
  logic [ACC_WIDTH-1:0]      acc_d;
  logic [ACC_WIDTH-1:0]      result_q;
  logic                      resultValid_q;
  logic                      inReady_q;
  logic                      busy_q;

  logic                      accept;
  logic                      lastAccept;
  logic                      handshake;
  logic                      clearAcc;
  logic [2*DATA_WIDTH-1:0]   mulRes;
  logic [ACC_WIDTH-1:0]      prodExt;

  assign in_ready     = inReady_q;
  assign result       = result_q;
  assign result_valid = resultValid_q;
  assign busy         = busy_q;

  assign accept     = in_valid && inReady_q;
  assign lastAccept = accept && (cnt_q == LAST_IDX);
  assign handshake  = (state_q == DONE) && resultValid_q && result_ready;
  assign clearAcc   = ((state_q == IDLE) && start) || (handshake && start);

  // Operands are widened to the full product width first, so the multiply never truncates.
`ifdef DOT_SIGNED_EN
  assign mulRes  = $signed({{DATA_WIDTH{a_data[DATA_WIDTH-1]}}, a_data}) *
                   $signed({{DATA_WIDTH{b_data[DATA_WIDTH-1]}}, b_data});
  assign prodExt = ACC_WIDTH'($signed(prod_q));
`else
  assign mulRes  = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
  assign prodExt = ACC_WIDTH'(prod_q);
`endif

  always_comb begin
    acc_d = acc_q;
    if (clearAcc) begin
      acc_d = '0;
    end else if (prodVld_q) begin
      acc_d = acc_q + prodExt;
    end
  end

  // Stage 1 registers the product; stage 2 folds it into the running sum one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      prodVld_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      prodVld_q <= accept;
      if (accept) begin
        prod_q <= mulRes;
      end
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      result_q      <= '0;
      resultValid_q <= 1'b0;
      inReady_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            state_q   <= ACCUM;
            inReady_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
          if (lastAccept) begin
            state_q   <= DRAIN;
            inReady_q <= 1'b0;
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          // The sum settles on the DRAIN edge, so it is captured one edge into DONE.
          if (!resultValid_q) begin
            resultValid_q <= 1'b1;
            result_q      <= acc_q;
          end else if (result_ready) begin
            resultValid_q <= 1'b0;
            result_q      <= '0;
            if (start) begin
              cnt_q     <= '0;
              state_q   <= ACCUM;
              inReady_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          inReady_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_mac_accumulator.sv
// Directed self-checking bench for dot_mac_accumulator; inputs change and outputs are sampled on the falling edge.
module tb_dot_mac_accumulator;

  localparam int DATA_WIDTH   = 8;
  localparam int VECTOR_WIDTH = 4;
  localparam int ACC_WIDTH    = 18;
  localparam int CNT_WIDTH    = 3;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [DATA_WIDTH-1:0] a_data;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;
  logic                  busy;

  int assertCount = 0;
  int failCount   = 0;

  dot_mac_accumulator #(
    .DATA_WIDTH  (DATA_WIDTH),
    .VECTOR_WIDTH(VECTOR_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_data      (a_data),
    .b_data      (b_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  task automatic startOp(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_inready_after_start"}, 32'(in_ready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int gaps);
    a_data   = a;
    b_data   = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(negedge clk);
    end
  endtask

  task automatic waitResult(input string tag, input int maxCycles, output int cycles);
    cycles = 0;
    while (!result_valid && cycles < maxCycles) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput({tag, "_valid_seen"}, 32'(result_valid), 32'd1);
  endtask

  task automatic collectResult(input string tag, input logic [31:0] expected);
    int cycles;
    waitResult(tag, 20, cycles);
    checkOutput({tag, "_result"}, 32'(result), expected);
    checkOutput({tag, "_inready_done"}, 32'(in_ready), 32'd0);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput({tag, "_valid_dropped"}, 32'(result_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int cycles;
    logic [31:0] expT3b;
    logic [31:0] expT6;
`ifdef DOT_SIGNED_EN
    expT3b = 32'd4;
    expT6  = 32'h3FFF8;
`else
    expT3b = 32'd260100;
    expT6  = 32'd2040;
`endif

    rst_n        = 1'b0;
    start        = 1'b0;
    a_data       = '0;
    b_data       = '0;
    in_valid     = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_inready", 32'(in_ready), 32'd0);
    checkOutput("reset_valid", 32'(result_valid), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: back-to-back pairs, latency from last accept
    startOp("t1");
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(8'd1, 8'd5, 0);
    applyStimulus(8'd2, 8'd6, 0);
    applyStimulus(8'd3, 8'd7, 0);
    applyStimulus(8'd4, 8'd8, 0);
    checkOutput("t1_inready_drain", 32'(in_ready), 32'd0);
    waitResult("t1", 20, cycles);
    checkOutput("t1_latency", 32'(cycles), 32'd2);
    checkOutput("t1_result", 32'(result), 32'd70);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("t1_valid_dropped", 32'(result_valid), 32'd0);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // in_valid in IDLE is ignored
    applyStimulus(8'd50, 8'd50, 1);
    checkOutput("idle_drop_busy", 32'(busy), 32'd0);

    // T2: gaps between pairs plus a stray start mid-operation
    startOp("t2");
    applyStimulus(8'd10, 8'd2, 2);
    checkOutput("t2_inready_gap", 32'(in_ready), 32'd1);
    start = 1'b1;
    applyStimulus(8'd20, 8'd4, 2);
    start = 1'b0;
    applyStimulus(8'd30, 8'd6, 2);
    applyStimulus(8'd40, 8'd8, 0);
    collectResult("t2", 32'd600);

    // T3: zero products, then full-scale operands
    startOp("t3a");
    applyStimulus(8'd0, 8'd3, 0);
    applyStimulus(8'd15, 8'd0, 0);
    applyStimulus(8'd0, 8'd7, 0);
    applyStimulus(8'd25, 8'd0, 0);
    collectResult("t3a", 32'd0);
    startOp("t3b");
    for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255, 0);
    collectResult("t3b", expT3b);

    // T4: consumer stalls in DONE; dropped pairs and ignored start
    startOp("t4");
    for (int i = 0; i < 4; i++) applyStimulus(8'd5, 8'd6, 0);
    waitResult("t4", 20, cycles);
    for (int i = 0; i < 5; i++) begin
      a_data   = 8'd9;
      b_data   = 8'd9;
      in_valid = (i % 2 == 0);
      start    = (i == 3);
      @(negedge clk);
      checkOutput("t4_hold_valid", 32'(result_valid), 32'd1);
      checkOutput("t4_hold_result", 32'(result), 32'd120);
      checkOutput("t4_hold_inready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    // start together with result_ready goes straight back to ACCUM
    start        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    result_ready = 1'b0;
    checkOutput("t4_restart_valid", 32'(result_valid), 32'd0);
    checkOutput("t4_restart_inready", 32'(in_ready), 32'd1);
    checkOutput("t4_restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(8'd1, 8'd1, 0);
    collectResult("t4", 32'd4);

    // T5: asynchronous reset mid-operation
    startOp("t5");
    applyStimulus(8'd7, 8'd7, 0);
    applyStimulus(8'd7, 8'd7, 0);
    checkOutput("t5_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_inready", 32'(in_ready), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_valid", 32'(result_valid), 32'd0);
    checkOutput("t5_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    startOp("t5b");
    for (int i = 0; i < 4; i++) applyStimulus(8'd2, 8'd3, 0);
    collectResult("t5b", 32'd24);

    // T6: operand with the top bit set
    startOp("t6");
    for (int i = 0; i < 4; i++) applyStimulus(8'hFF, 8'h02, 0);
    collectResult("t6", expT6);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
